// File: rtl/program_loader.sv
// program_loader: boot-time writer for the processor's unified memory.
// Takes a byte stream over valid/ready, writes the bytes to consecutive
// addresses starting at START_ADDR, then checks a trailing checksum byte
// (image bytes + checksum must sum to zero modulo 2**DATA_W). The processor
// is held stalled until an image has loaded cleanly.
module program_loader #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Largest legal image: every memory location exactly once.
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t              state_r, state_next_s;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   sum_r;
  logic [DATA_W-1:0]   sum_chk_s;
  logic                accept_s;
  logic                len_ok_s;
  logic                can_start_s;
  logic                start_load_s;

  logic                in_ready_r, in_ready_s;
  logic                cpu_hold_r, cpu_hold_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                error_r, error_s;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;

  // in_ready is registered, so the accept decision never looks back at in_valid combinationally.
  assign accept_s     = in_valid && in_ready_r;
  assign len_ok_s     = (len != CNT_ZERO) && (len <= MAX_LEN);
  assign can_start_s  = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR);
  assign start_load_s = start && can_start_s && len_ok_s;
  assign sum_chk_s    = sum_r + in_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; start is honoured only while not mid-load.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next_s = len_ok_s ? ST_LOAD : ST_ERROR;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s && (count_r == CNT_ONE)) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          state_next_s = (sum_chk_s == DATA_ZERO) ? ST_DONE : ST_ERROR;
        end else begin
          state_next_s = ST_CHECK;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so the registered copies match the state.
  always_comb begin
    in_ready_s = 1'b0;
    cpu_hold_s = 1'b1;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    case (state_next_s)
      ST_IDLE:  begin end
      ST_LOAD:  begin in_ready_s = 1'b1; busy_s = 1'b1; end
      ST_CHECK: begin in_ready_s = 1'b1; busy_s = 1'b1; end
      ST_DONE:  begin done_s = 1'b1; cpu_hold_s = 1'b0; end
      ST_ERROR: begin error_s = 1'b1; end
      default:  begin end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b0;
      cpu_hold_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      cpu_hold_r <= cpu_hold_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  // Load datapath: one memory write the cycle after each image byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= CNT_ZERO;
      addr_r      <= START_ADDR;
      sum_r       <= DATA_ZERO;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= START_ADDR;
      mem_wdata_r <= DATA_ZERO;
    end else begin
      mem_we_r <= 1'b0;
      if (start_load_s) begin
        count_r <= len;
        addr_r  <= START_ADDR;
        sum_r   <= DATA_ZERO;
      end else if ((state_r == ST_LOAD) && accept_s) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= addr_r;
        mem_wdata_r <= in_data;
        addr_r      <= addr_r + ADDR_ONE;
        sum_r       <= sum_chk_s;
        count_r     <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign cpu_hold  = cpu_hold_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Two instances share the stimulus:
// dut_a loads from address 0, dut_b from 0xFE to exercise address wrap.
module tb_program_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] len;
  logic [7:0] in_data;
  logic       in_valid;

  logic       in_ready_a, mem_we_a, cpu_hold_a, busy_a, done_a, error_a;
  logic [7:0] mem_addr_a, mem_wdata_a;
  logic       in_ready_b, mem_we_b, cpu_hold_b, busy_b, done_b, error_b;
  logic [7:0] mem_addr_b, mem_wdata_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Write log entries: {cycle[15:0], addr, data}
  logic [31:0] wq_a[$];
  logic [31:0] wq_b[$];

  program_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .error(error_a)
  );

  program_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .error(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to timestamp memory writes.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we_a === 1'b1) wq_a.push_back({cyc[15:0], mem_addr_a, mem_wdata_a});
    if (mem_we_b === 1'b1) wq_b.push_back({cyc[15:0], mem_addr_b, mem_wdata_b});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one logged write (address and data) against expectations.
  task automatic check_write(input string tag, input bit use_b, input int idx,
                             input logic [7:0] addr, input logic [7:0] data);
    logic [31:0] e;
    e = 32'hxxxxxxxx;
    if (!use_b && idx < wq_a.size()) e = wq_a[idx];
    if (use_b && idx < wq_b.size()) e = wq_b[idx];
    check_eq(tag, {16'h0000, e[15:0]}, {16'h0000, addr, data});
  endtask

  task automatic start_load(input logic [8:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wq_a.delete();
    wq_b.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 9'd0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_in_ready", in_ready_a, 1'b0);
    check_eq("rst_mem_we",   mem_we_a,   1'b0);
    check_eq("rst_addr_a",   mem_addr_a, 8'h00);
    check_eq("rst_addr_b",   mem_addr_b, 8'hFE);
    check_eq("rst_wdata",    mem_wdata_a, 8'h00);
    check_eq("rst_status",   {cpu_hold_a, busy_a, done_a, error_a}, 4'b1000);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal load: 0x21+0x42+0x03+0x9A = 0x100
    clear_logs();
    start_load(9'd3);
    check_eq("nom_ready_busy", {in_ready_a, busy_a, cpu_hold_a}, 3'b111);
    send_byte(8'h21);
    check_eq("nom_lat1_we", mem_we_a, 1'b1);
    send_byte(8'h42);
    send_byte(8'h03);
    send_byte(8'h9A);
    idle_cycle();
    check_eq("nom_nwrites", wq_a.size(), 3);
    check_write("nom_w0", 1'b0, 0, 8'h00, 8'h21);
    check_write("nom_w1", 1'b0, 1, 8'h01, 8'h42);
    check_write("nom_w2", 1'b0, 2, 8'h02, 8'h03);
    if (wq_a.size() == 3)
      check_eq("nom_consecutive", wq_a[2][31:16] - wq_a[0][31:16], 16'd2);
    check_eq("nom_status", {done_a, cpu_hold_a, error_a, busy_a, in_ready_a}, 5'b10000);

    // Bad checksum
    clear_logs();
    start_load(9'd3);
    check_eq("bad_hold_on_restart", {cpu_hold_a, done_a}, 2'b10);
    send_byte(8'h21);
    send_byte(8'h42);
    send_byte(8'h03);
    send_byte(8'h9B);
    idle_cycle();
    check_eq("bad_nwrites", wq_a.size(), 3);
    check_write("bad_w2", 1'b0, 2, 8'h02, 8'h03);
    check_eq("bad_status", {error_a, cpu_hold_a, done_a, busy_a}, 4'b1100);

    // Retry from ERROR: 0x05+0xFB = 0x100
    clear_logs();
    start_load(9'd1);
    check_eq("retry_err_clear", error_a, 1'b0);
    send_byte(8'h05);
    send_byte(8'hFB);
    idle_cycle();
    check_write("retry_w0", 1'b0, 0, 8'h00, 8'h05);
    check_eq("retry_done", {done_a, error_a, cpu_hold_a}, 3'b100);

    // Stalled source: valid 1,0,0,1 then checksum; 0x10+0x20+0xD0 = 0x100
    clear_logs();
    start_load(9'd2);
    send_byte(8'h10);
    check_eq("stall_we_c0", {mem_we_a, mem_addr_a, mem_wdata_a}, {1'b1, 8'h00, 8'h10});
    in_data = 8'h77;
    idle_cycle();
    check_eq("stall_we_c1", mem_we_a, 1'b0);
    idle_cycle();
    check_eq("stall_we_c2", mem_we_a, 1'b0);
    send_byte(8'h20);
    check_eq("stall_we_c3", {mem_we_a, mem_addr_a, mem_wdata_a}, {1'b1, 8'h01, 8'h20});
    send_byte(8'hD0);
    check_eq("stall_we_c4", mem_we_a, 1'b0);
    idle_cycle();
    check_eq("stall_nwrites", wq_a.size(), 2);
    check_eq("stall_done", done_a, 1'b1);

    // Illegal len = 0
    clear_logs();
    start_load(9'd0);
    idle_cycle();
    check_eq("len0_status", {error_a, done_a, busy_a, in_ready_a, cpu_hold_a}, 5'b10001);
    check_eq("len0_nwrites", wq_a.size(), 0);

    // Illegal len = 257
    start_load(9'd257);
    check_eq("len257_error", {error_a, busy_a}, 2'b10);

    // start pulsed mid-load is ignored: 1+2+3+4 = 0x0A, checksum 0xF6
    clear_logs();
    start_load(9'd4);
    send_byte(8'h01);
    start = 1'b1;
    len   = 9'd1;
    send_byte(8'h02);
    start = 1'b0;
    send_byte(8'h03);
    send_byte(8'h04);
    check_eq("ign_in_check", {busy_a, in_ready_a, done_a}, 3'b110);
    send_byte(8'hF6);
    idle_cycle();
    check_eq("ign_nwrites", wq_a.size(), 4);
    check_write("ign_w3", 1'b0, 3, 8'h03, 8'h04);
    check_eq("ign_done", done_a, 1'b1);

    // Wrap on dut_b: 0xAA+0xBB+0xCC+0xCF = 0x300
    clear_logs();
    start_load(9'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hCF);
    idle_cycle();
    check_eq("wrap_nwrites", wq_b.size(), 3);
    check_write("wrap_w0", 1'b1, 0, 8'hFE, 8'hAA);
    check_write("wrap_w1", 1'b1, 1, 8'hFF, 8'hBB);
    check_write("wrap_w2", 1'b1, 2, 8'h00, 8'hCC);
    check_eq("wrap_done", {done_b, error_b}, 2'b10);

    // Async reset mid-load
    clear_logs();
    start_load(9'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("arst_pre_we", mem_we_a, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_outputs", {mem_we_a, in_ready_a, busy_a, cpu_hold_a, done_a, error_a},
             6'b000100);
    check_eq("arst_addr", mem_addr_a, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_idle", {in_ready_a, busy_a, cpu_hold_a}, 3'b001);
    start_load(9'd1);
    send_byte(8'h05);
    send_byte(8'hFB);
    check_eq("arst_reload_done", done_a, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the processor's unified instruction/data memory; counterpart to the processor's fetch path, which only reads memory.
- Accepts a byte stream over a valid/ready handshake, writes each byte to consecutive memory addresses, then checks a trailing checksum byte.
- Holds the processor stalled until the image loads cleanly.
- Sits between an external host/serial front-end and the memory write port, which it muxes ahead of the processor.

Parameters:
- ADDR_W, 8, memory address width; memory depth is 2**ADDR_W.
- DATA_W, 8, byte width; matches the 8-bit instruction word {opcode[2:0], immediate[4:0]}.
- START_ADDR, 0, first address written; the processor's pc reset target.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
- len  input  ADDR_W+1  number of image bytes, excluding the checksum byte; sampled with start; valid range 1..2**ADDR_W.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_W  memory write address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable, one cycle per byte.
- cpu_hold  output  1  high keeps the processor stalled and the memory port owned by the loader.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  image loaded and checksum good.
- error  output  1  checksum mismatch or illegal len.

Behaviour:
- Reset (rst_n low, immediate and asynchronous):
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0.
  - The internal count and sum registers clear to 0.
  - A reset in the middle of a load drops mem_we at once and abandons the load. There is no resume.
- Handshake:
  - A byte transfers on a rising edge where in_valid && in_ready.
  - in_valid with in_ready=0 is ignored, and the byte is not consumed.
  - in_ready is a registered state decode; it does not depend combinationally on in_valid.
- States:
  - IDLE: in_ready=0, cpu_hold=1.
    - start && len in range -> latch len into count, addr=START_ADDR, sum=0, go to LOAD.
    - start && (len==0 or len>2**ADDR_W) -> go to ERROR.
  - LOAD: in_ready=1, busy=1.
    - Per transfer: the cycle after acceptance drives mem_we=1, mem_addr=addr, mem_wdata=byte. Then addr+=1 (wraps modulo 2**ADDR_W), sum+=byte (modulo 2**DATA_W), count-=1.
    - Latency is fixed at 1 cycle from the accept edge to mem_we high.
    - Back-to-back transfers hold mem_we high continuously, with the address stepping by 1 per cycle.
    - When the accepted byte makes count reach 0, go to CHECK.
  - CHECK: in_ready=1, busy=1.
    - Accept exactly one byte, the checksum, which is never written to memory.
    - (sum + byte) mod 2**DATA_W == 0 -> DONE; otherwise -> ERROR.
    - The final image byte's mem_we pulse occurs in the first CHECK cycle.
  - DONE: done=1, cpu_hold=0, in_ready=0.
    - start -> begin a new load exactly as from IDLE: cpu_hold=1 on the next edge, done cleared.
  - ERROR: error=1, cpu_hold=1, in_ready=0.
    - start -> retry as from IDLE, error cleared.
- start in LOAD or CHECK is ignored.
- len is not re-sampled mid-load.
- done and error are never high together.
- busy is high iff the state is LOAD or CHECK.
- Wrap: START_ADDR+len beyond the top of memory wraps to address 0. len=2**ADDR_W writes every location exactly once.

Test Plan:
- Nominal load: reset, start with len=3, stream 0x21,0x42,0x03 then checksum 0x9A with in_valid held high.
  - Required: mem_we high for 3 consecutive cycles at addr 0,1,2 with data 0x21,0x42,0x03.
  - Required: done=1, cpu_hold=0, error=0.
- Bad checksum: same stream with checksum 0x9B.
  - Required: the 3 writes still occur; then error=1, cpu_hold=1, done=0.
  - Then start with len=1, stream 0x05, checksum 0xFB -> done=1.
- Stalled source: len=2, bytes 0x10,0x20 with in_valid toggling 1,0,0,1, then checksum 0xD0.
  - Required: exactly 2 mem_we pulses, each 1 cycle after its accept edge, at addr 0 and 1; done=1.
- Illegal len and ignored start:
  - start with len=0 -> ERROR and no mem_we.
  - start pulsed during LOAD of len=4 -> no effect; 4 writes occur.
- Wrap: START_ADDR=0xFE, len=3, bytes 0xAA,0xBB,0xCC, checksum 0xCF.
  - Required: writes to 0xFE, 0xFF, 0x00; done=1.
- Async reset mid-load: assert rst_n low between clock edges after the 2nd byte of len=4.
  - Required: mem_we=0, in_ready=0, busy=0 before the next edge; state IDLE; cpu_hold=1.
